crossbar_allocator: RTL and testbench

- Switch-allocation stage directly downstream of each input port's Buffer, alongside the Crossbar Switch.
- Per output port, arbitrates among input-port crossbar requests with round-robin priority.
- Locks each output to one input from head flit to tail flit, and gates every grant on downstream per-VC credits.
- Drives each Buffer's cba_grant and the crossbar select lines in the same cycle as the request.

---
 rtl/noc_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/crossbar_allocator.sv | 176 +++++++++++++++++
 tb/tb_crossbar_allocator.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions used by the router pipeline stages.
//   - Flit type codes carried in flit bits [FLIT_TYPE_MSB:FLIT_TYPE_LSB].
//   - Router port index constants (N, S, E, W, Local).
package noc_pkg;

  localparam int unsigned FLIT_TYPE_MSB = 47;
  localparam int unsigned FLIT_TYPE_LSB = 45;

  // Codes 1xx are not listed; consumers treat them as body flits.
  typedef enum logic [2:0] {
    FLIT_HEAD     = 3'b000,
    FLIT_BODY     = 3'b001,
    FLIT_TAIL     = 3'b010,
    FLIT_HEADTAIL = 3'b011
  } flit_type_e;

  localparam logic [2:0] PORT_N = 3'd0;
  localparam logic [2:0] PORT_S = 3'd1;
  localparam logic [2:0] PORT_E = 3'd2;
  localparam logic [2:0] PORT_W = 3'd3;
  localparam logic [2:0] PORT_L = 3'd4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i : request vector, one bit per input
//   ptr_i : highest-priority input index (0..NUM_PORTS-1)
//   gnt_o : one-hot grant vector
//   idx_o : index of the winning input (0 when none)
//   any_o : at least one request was granted
module rr_arbiter #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned PORT_W    = 3
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PORT_W-1:0]    ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [PORT_W-1:0]    idx_o,
  output logic                 any_o
);

  // Two passes: first the inputs at or above the pointer, then the
  // wrapped-around inputs below it.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!any_o && req_i[i] && (i >= 32'(ptr_i))) begin
        any_o    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = PORT_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (!any_o && req_i[i] && (i < 32'(ptr_i))) begin
        any_o    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = PORT_W'(i);
      end
    end
  end

endmodule

// File: rtl/crossbar_allocator.sv
// Switch allocator: per-output round-robin arbitration with head-to-tail
// packet locking and per-VC downstream credit gating.
//   clk, rst          : clock, asynchronous active-low reset
//   req/req_port/req_vc/req_type : per-input request, target output, VC, flit type
//   credit_in/credit_vc : per-output credit return pulse and its VC
//   grant             : per-input grant (same cycle as request)
//   xbar_sel/xbar_valid : per-output winning input index and valid strobe
module crossbar_allocator #(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned PORT_W    = 3,
  parameter int unsigned NUM_VCS   = 2,
  parameter int unsigned CREDITS   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS*PORT_W-1:0]   req_port,
  input  logic [NUM_PORTS*2-1:0]        req_vc,
  input  logic [NUM_PORTS*3-1:0]        req_type,
  input  logic [NUM_PORTS-1:0]          credit_in,
  input  logic [NUM_PORTS*2-1:0]        credit_vc,
  output logic [NUM_PORTS-1:0]          grant,
  output logic [NUM_PORTS*PORT_W-1:0]   xbar_sel,
  output logic [NUM_PORTS-1:0]          xbar_valid
);

  import noc_pkg::*;

  localparam logic [2:0] CREDIT_MAX = 3'(CREDITS);

  logic              lock_valid_q [NUM_PORTS];
  logic              lock_valid_d [NUM_PORTS];
  logic [PORT_W-1:0] lock_owner_q [NUM_PORTS];
  logic [PORT_W-1:0] lock_owner_d [NUM_PORTS];
  logic [PORT_W-1:0] rr_ptr_q     [NUM_PORTS];
  logic [PORT_W-1:0] rr_ptr_d     [NUM_PORTS];
  logic [2:0]        credit_q     [NUM_PORTS][NUM_VCS];
  logic [2:0]        credit_d     [NUM_PORTS][NUM_VCS];

  logic [PORT_W-1:0]    in_port [NUM_PORTS];
  logic [1:0]           in_vc   [NUM_PORTS];
  logic [2:0]           in_type [NUM_PORTS];

  logic [NUM_PORTS-1:0] elig    [NUM_PORTS];
  logic [NUM_PORTS-1:0] win_gnt [NUM_PORTS];
  logic [PORT_W-1:0]    win_idx [NUM_PORTS];
  logic                 win_any [NUM_PORTS];

  always_comb begin
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      in_port[i] = req_port[i*PORT_W +: PORT_W];
      in_vc[i]   = req_vc[i*2 +: 2];
      in_type[i] = req_type[i*3 +: 3];
    end
  end

  // Eligibility matrix, one row per output. An out-of-range req_port or
  // req_vc simply never matches any row / VC index.
  always_comb begin
    logic credit_ok;
    logic lock_ok;
    credit_ok = 1'b0;
    lock_ok   = 1'b0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      elig[o] = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        credit_ok = 1'b0;
        for (int unsigned v = 0; v < NUM_VCS; v++) begin
          if (in_vc[i] == 2'(v) && credit_q[o][v] != '0) credit_ok = 1'b1;
        end
        if (lock_valid_q[o]) lock_ok = (lock_owner_q[o] == PORT_W'(i));
        else                 lock_ok = (in_type[i] == FLIT_HEAD) ||
                                       (in_type[i] == FLIT_HEADTAIL);
        elig[o][i] = req[i] && (in_port[i] == PORT_W'(o)) && credit_ok && lock_ok;
      end
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .PORT_W    (PORT_W)
    ) u_arb (
      .req_i (elig[o]),
      .ptr_i (rr_ptr_q[o]),
      .gnt_o (win_gnt[o]),
      .idx_o (win_idx[o]),
      .any_o (win_any[o])
    );
  end

  // Outputs are masked combinationally by rst so they drop the moment
  // reset asserts, not at the next edge.
  always_comb begin
    grant      = '0;
    xbar_sel   = '0;
    xbar_valid = '0;
    if (rst) begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        if (win_any[o]) begin
          xbar_valid[o]                  = 1'b1;
          xbar_sel[o*PORT_W +: PORT_W]   = win_idx[o];
          grant                          = grant | win_gnt[o];
        end
      end
    end
  end

  always_comb begin
    logic [2:0] win_type;
    logic [1:0] win_vc;
    logic       dec;
    logic       inc;
    win_type = '0;
    win_vc   = '0;
    dec      = 1'b0;
    inc      = 1'b0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      lock_valid_d[o] = lock_valid_q[o];
      lock_owner_d[o] = lock_owner_q[o];
      rr_ptr_d[o]     = rr_ptr_q[o];
      win_type        = '0;
      win_vc          = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (win_gnt[o][i]) begin
          win_type = in_type[i];
          win_vc   = in_vc[i];
        end
      end
      if (win_any[o]) begin
        case (win_type)
          FLIT_HEAD: begin
            lock_valid_d[o] = 1'b1;
            lock_owner_d[o] = win_idx[o];
            rr_ptr_d[o]     = (win_idx[o] == PORT_W'(NUM_PORTS-1)) ? '0
                                                                   : win_idx[o] + PORT_W'(1);
          end
          FLIT_TAIL: lock_valid_d[o] = 1'b0;
          FLIT_HEADTAIL: begin
            rr_ptr_d[o] = (win_idx[o] == PORT_W'(NUM_PORTS-1)) ? '0
                                                               : win_idx[o] + PORT_W'(1);
          end
          default: ;
        endcase
      end
      // Grant consumes a credit, return adds one; both together cancel.
      // A grant is only possible with credit > 0, so no underflow.
      for (int unsigned v = 0; v < NUM_VCS; v++) begin
        dec = win_any[o] && (win_vc == 2'(v));
        inc = credit_in[o] && (credit_vc[o*2 +: 2] == 2'(v));
        credit_d[o][v] = credit_q[o][v];
        if (inc && !dec && credit_q[o][v] != CREDIT_MAX) credit_d[o][v] = credit_q[o][v] + 3'd1;
        else if (dec && !inc)                            credit_d[o][v] = credit_q[o][v] - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        lock_valid_q[o] <= 1'b0;
        lock_owner_q[o] <= '0;
        rr_ptr_q[o]     <= '0;
        for (int unsigned v = 0; v < NUM_VCS; v++) credit_q[o][v] <= CREDIT_MAX;
      end
    end else begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        lock_valid_q[o] <= lock_valid_d[o];
        lock_owner_q[o] <= lock_owner_d[o];
        rr_ptr_q[o]     <= rr_ptr_d[o];
        for (int unsigned v = 0; v < NUM_VCS; v++) credit_q[o][v] <= credit_d[o][v];
      end
    end
  end

endmodule

// File: tb/tb_crossbar_allocator.sv
// Self-checking bench for crossbar_allocator: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_crossbar_allocator;

  localparam int NP = 5;
  localparam int PW = 3;
  localparam int NV = 2;
  localparam int CR = 4;

  localparam int T_HEAD = 0;
  localparam int T_BODY = 1;
  localparam int T_TAIL = 2;
  localparam int T_HT   = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NP-1:0]     req;
  logic [NP*PW-1:0]  req_port;
  logic [NP*2-1:0]   req_vc;
  logic [NP*3-1:0]   req_type;
  logic [NP-1:0]     credit_in;
  logic [NP*2-1:0]   credit_vc;
  logic [NP-1:0]     grant;
  logic [NP*PW-1:0]  xbar_sel;
  logic [NP-1:0]     xbar_valid;

  crossbar_allocator #(
    .NUM_PORTS (NP),
    .PORT_W    (PW),
    .NUM_VCS   (NV),
    .CREDITS   (CR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_port   (req_port),
    .req_vc     (req_vc),
    .req_type   (req_type),
    .credit_in  (credit_in),
    .credit_vc  (credit_vc),
    .grant      (grant),
    .xbar_sel   (xbar_sel),
    .xbar_valid (xbar_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus
  int t_req [NP];
  int t_port[NP];
  int t_vc  [NP];
  int t_type[NP];
  int t_cin [NP];
  int t_cvc [NP];

  // reference model state
  int m_lv [NP];
  int m_lo [NP];
  int m_rr [NP];
  int m_cr [NP][NV];
  int m_win[NP];

  logic [NP-1:0]    e_grant;
  logic [NP-1:0]    e_valid;
  logic [NP*PW-1:0] e_sel;
  logic [NP-1:0]    s_grant;
  logic [NP*PW-1:0] s_sel;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < NP; i++) begin
      t_req[i] = 0; t_port[i] = 0; t_vc[i] = 0; t_type[i] = 0;
      t_cin[i] = 0; t_cvc[i] = 0;
    end
  endtask

  task automatic setin(input int i, input int port, input int vc, input int typ);
    t_req[i] = 1; t_port[i] = port; t_vc[i] = vc; t_type[i] = typ;
  endtask

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      req[i]             = (t_req[i] != 0);
      req_port[i*PW +: PW] = 3'(t_port[i]);
      req_vc[i*2 +: 2]   = 2'(t_vc[i]);
      req_type[i*3 +: 3] = 3'(t_type[i]);
      credit_in[i]       = (t_cin[i] != 0);
      credit_vc[i*2 +: 2] = 2'(t_cvc[i]);
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < NP; o++) begin
      m_lv[o] = 0; m_lo[o] = 0; m_rr[o] = 0;
      for (int v = 0; v < NV; v++) m_cr[o][v] = CR;
    end
  endtask

  function automatic bit m_elig(input int i, input int o);
    if (t_req[i] == 0) return 0;
    if (t_port[i] != o) return 0;
    if (t_vc[i] >= NV) return 0;
    if (m_cr[o][t_vc[i]] == 0) return 0;
    if (m_lv[o] != 0) return (m_lo[o] == i);
    return (t_type[i] == T_HEAD) || (t_type[i] == T_HT);
  endfunction

  task automatic model_eval();
    e_grant = '0; e_valid = '0; e_sel = '0;
    for (int o = 0; o < NP; o++) begin
      m_win[o] = -1;
      for (int k = 0; k < NP; k++) begin
        int i;
        i = (m_rr[o] + k) % NP;
        if (m_win[o] < 0 && m_elig(i, o)) m_win[o] = i;
      end
      if (m_win[o] >= 0) begin
        e_grant[m_win[o]] = 1'b1;
        e_valid[o] = 1'b1;
        e_sel[o*PW +: PW] = 3'(m_win[o]);
      end
    end
  endtask

  task automatic model_commit();
    for (int o = 0; o < NP; o++) begin
      int w;
      w = m_win[o];
      if (w >= 0) begin
        if (t_type[w] == T_HEAD) begin
          m_lv[o] = 1; m_lo[o] = w; m_rr[o] = (w + 1) % NP;
        end else if (t_type[w] == T_TAIL) begin
          m_lv[o] = 0;
        end else if (t_type[w] == T_HT) begin
          m_rr[o] = (w + 1) % NP;
        end
      end
      for (int v = 0; v < NV; v++) begin
        int d, inc;
        d   = (w >= 0 && t_vc[w] == v) ? 1 : 0;
        inc = (t_cin[o] != 0 && t_cvc[o] == v) ? 1 : 0;
        m_cr[o][v] = m_cr[o][v] - d + inc;
        if (m_cr[o][v] > CR) m_cr[o][v] = CR;
      end
    end
  endtask

  function automatic logic [63:0] probe_cr();
    logic [63:0] r;
    r = '0;
    for (int o = 0; o < NP; o++)
      for (int v = 0; v < NV; v++) r[(o*NV+v)*3 +: 3] = dut.credit_q[o][v];
    return r;
  endfunction

  function automatic logic [63:0] probe_lock();
    logic [63:0] r;
    r = '0;
    for (int o = 0; o < NP; o++) begin
      r[o] = dut.lock_valid_q[o];
      r[8 + o*PW +: PW]  = dut.lock_owner_q[o];
      r[32 + o*PW +: PW] = dut.rr_ptr_q[o];
    end
    return r;
  endfunction

  task automatic check_state();
    logic [63:0] ecr, elk;
    ecr = '0; elk = '0;
    for (int o = 0; o < NP; o++) begin
      for (int v = 0; v < NV; v++) ecr[(o*NV+v)*3 +: 3] = 3'(m_cr[o][v]);
      elk[o] = (m_lv[o] != 0);
      elk[8 + o*PW +: PW]  = 3'(m_lo[o]);
      elk[32 + o*PW +: PW] = 3'(m_rr[o]);
    end
    check("credits", probe_cr(), ecr);
    check("lock_ptr", probe_lock(), elk);
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    model_eval();
    check("grant", 64'(grant), 64'(e_grant));
    check("xbar_valid", 64'(xbar_valid), 64'(e_valid));
    check("xbar_sel", 64'(xbar_sel), 64'(e_sel));
    check_state();
    s_grant = grant;
    s_sel   = xbar_sel;
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < NP; i++) setin(i, $urandom_range(0, NP-1), 0, T_HEAD);
    drive();
    rst = 1'b0;
    #1;
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_valid", 64'(xbar_valid), 64'd0);
    check("rst_sel", 64'(xbar_sel), 64'd0);
    model_reset();
    check_state();
    @(posedge clk);
    #1;
    rst = 1'b1;
    clr();
    drive();
  endtask

  task automatic refill();
    clr();
    for (int k = 0; k < CR; k++)
      for (int v = 0; v < NV; v++) begin
        for (int o = 0; o < NP; o++) begin t_cin[o] = 1; t_cvc[o] = v; end
        step();
      end
    clr();
  endtask

  initial begin
    int gcount;
    logic [63:0] snap_cr, snap_lk;
    clr();
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset then idle
    step();
    check("reset_credits", probe_cr(), {34'd0, {10{3'd4}}});
    check("idle_grant", 64'(s_grant), 64'd0);

    // Three inputs contend for output 2 (single-flit packets)
    clr();
    setin(0, 2, 0, T_HT); setin(2, 2, 0, T_HT); setin(3, 2, 0, T_HT);
    step();
    check("contend_g0", 64'(s_grant), 64'b00001);
    check("contend_sel0", 64'(s_sel[2*PW +: PW]), 64'd0);
    t_req[0] = 0;
    step();
    check("contend_g1", 64'(s_grant), 64'b00100);
    step();
    check("contend_g2", 64'(s_grant), 64'b01000);
    check("contend_sel2", 64'(s_sel[2*PW +: PW]), 64'd3);
    refill();

    // Packet lock on output 4
    clr();
    setin(1, 4, 0, T_HEAD); setin(3, 4, 1, T_HEAD);
    step(); check("lock_head", 64'(s_grant), 64'b00010);
    t_type[1] = T_BODY;
    step(); check("lock_body", 64'(s_grant), 64'b00010);
    t_type[1] = T_TAIL;
    step(); check("lock_tail", 64'(s_grant), 64'b00010);
    t_req[1] = 0;
    step(); check("lock_next", 64'(s_grant), 64'b01000);
    t_type[3] = T_TAIL;
    step(); check("lock_next_tail", 64'(s_grant), 64'b01000);
    refill();

    // Credit exhaustion on output 1 VC1
    clr();
    gcount = 0;
    setin(0, 1, 1, T_HEAD);
    step(); gcount += int'(s_grant[0]);
    t_type[0] = T_BODY;
    for (int k = 0; k < 6; k++) begin step(); gcount += int'(s_grant[0]); end
    check("credit_exhaust_cnt", 64'(gcount), 64'd4);
    gcount = 0;
    t_cin[1] = 1; t_cvc[1] = 1;
    step(); gcount += int'(s_grant[0]);
    t_cin[1] = 0;
    for (int k = 0; k < 3; k++) begin step(); gcount += int'(s_grant[0]); end
    check("credit_one_more", 64'(gcount), 64'd1);
    t_req[0] = 0; t_cin[1] = 1; t_cvc[1] = 1;
    step();
    t_req[0] = 1;
    step();
    check("credit_same_grant", 64'(s_grant), 64'b00001);
    check("credit_same_cnt", 64'(dut.credit_q[1][1]), 64'd1);
    t_cin[1] = 0; t_type[0] = T_TAIL;
    step();
    check("credit_tail", 64'(s_grant), 64'b00001);
    refill();

    // Illegal flits
    clr();
    setin(4, 0, 0, T_BODY); setin(2, 6, 0, T_HEAD);
    snap_cr = probe_cr(); snap_lk = probe_lock();
    step();
    check("illegal_grant", 64'(s_grant), 64'd0);
    check("illegal_cr", probe_cr(), snap_cr);
    check("illegal_lk", probe_lock(), snap_lk);

    // Mid-packet reset
    clr();
    setin(2, 3, 0, T_HEAD);
    step(); check("mid_head", 64'(s_grant), 64'b00100);
    t_type[2] = T_BODY;
    step();
    do_reset();
    clr();
    setin(0, 3, 0, T_HEAD);
    step(); check("post_rst_head", 64'(s_grant), 64'b00001);
    t_type[0] = T_TAIL;
    step();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      clr();
      for (int i = 0; i < NP; i++) begin
        t_req[i]  = ($urandom_range(0, 3) != 0) ? 1 : 0;
        t_port[i] = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 7) : $urandom_range(0, NP-1);
        t_vc[i]   = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 3) : $urandom_range(0, 1);
        t_type[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
        t_cin[i]  = $urandom_range(0, 1);
        t_cvc[i]  = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 3) : $urandom_range(0, 1);
      end
      step();
      if (n == 200) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
